// File: rtl/axi4_lite_master_if.sv
// Purpose : bundles the command/response handshake and the AXI4-Lite master
//           channels of axi4_lite_master into one interface.
// Ports   : command (cmd_*), response (rsp_*), AW/W/B and AR/R channels (M_*).
// Modports: master = the bridge itself, slave = the environment around it
//           (command source, response sink and AXI slave).
interface axi4_lite_master_if #(
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    // Command / response side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDRESS-1:0]    cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_W-1:0]     cmd_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;

    // AXI4-Lite channels
    logic [ADDRESS-1:0]    M_AWADDR;
    logic                  M_AWVALID;
    logic                  M_AWREADY;
    logic [DATA_WIDTH-1:0] M_WDATA;
    logic [STRB_W-1:0]     M_WSTRB;
    logic                  M_WVALID;
    logic                  M_WREADY;
    logic [1:0]            M_BRESP;
    logic                  M_BVALID;
    logic                  M_BREADY;
    logic [ADDRESS-1:0]    M_ARADDR;
    logic                  M_ARVALID;
    logic                  M_ARREADY;
    logic [DATA_WIDTH-1:0] M_RDATA;
    logic [1:0]            M_RRESP;
    logic                  M_RVALID;
    logic                  M_RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output M_AWADDR, M_AWVALID,
        input  M_AWREADY,
        output M_WDATA, M_WSTRB, M_WVALID,
        input  M_WREADY,
        input  M_BRESP, M_BVALID,
        output M_BREADY,
        output M_ARADDR, M_ARVALID,
        input  M_ARREADY,
        input  M_RDATA, M_RRESP, M_RVALID,
        output M_RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  M_AWADDR, M_AWVALID,
        output M_AWREADY,
        input  M_WDATA, M_WSTRB, M_WVALID,
        output M_WREADY,
        output M_BRESP, M_BVALID,
        input  M_BREADY,
        input  M_ARADDR, M_ARVALID,
        output M_ARREADY,
        output M_RDATA, M_RRESP, M_RVALID,
        input  M_RREADY
    );
endinterface

// File: rtl/axi4_lite_master.sv
// Purpose : single-outstanding AXI4-Lite master. Accepts one read or write
//           command, runs it on the AXI channels and returns the slave's
//           response (data + resp code) through a valid/ready handshake.
// Ports   : ACLK   - rising-edge clock
//           ARESET - asynchronous active-high reset
//           bus    - axi4_lite_master_if.master (cmd_*, rsp_*, M_* channels)
// Config  : AXI_MASTER_ALIGN_CHECK_EN - when defined, commands whose address
//           is not aligned to the data width are answered locally with
//           SLVERR (2'b10) and never reach the AXI bus.
// All outputs are registered except cmd_ready, which is decoded from state.
module axi4_lite_master #(
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic               ACLK,
    input  logic               ARESET,
    axi4_lite_master_if.master bus
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                r_state;
    logic [ADDRESS-1:0]    r_awaddr;
    logic                  r_awvalid;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDRESS-1:0]    r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]            r_rsp_resp;

    logic w_cmd_ready;
    logic w_cmd_fire;
    logic w_aw_fire;
    logic w_w_fire;

    assign w_cmd_ready = (r_state == IDLE);
    assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
    assign w_aw_fire   = r_awvalid && bus.M_AWREADY;
    assign w_w_fire    = r_wvalid && bus.M_WREADY;

`ifdef AXI_MASTER_ALIGN_CHECK_EN
    localparam int unsigned OFFS_W = $clog2(STRB_W);
    logic w_misaligned;
    assign w_misaligned = (bus.cmd_addr[OFFS_W-1:0] != OFFS_W'(0));
`endif

    // Transaction sequencer; every bus-facing output is a register here.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
`ifdef AXI_MASTER_ALIGN_CHECK_EN
                        if (w_misaligned) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_resp  <= 2'b10;
                            r_state     <= DONE;
                        end else
`endif
                        if (bus.cmd_write) begin
                            r_awaddr  <= bus.cmd_addr;
                            r_wdata   <= bus.cmd_wdata;
                            r_wstrb   <= bus.cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WRITE;
                        end else begin
                            r_araddr  <= bus.cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RADDR;
                        end
                    end
                end
                WRITE: begin
                    // A low valid here means that channel already completed.
                    if (w_aw_fire) r_awvalid <= 1'b0;
                    if (w_w_fire)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || w_aw_fire) && (!r_wvalid || w_w_fire)) begin
                        r_bready <= 1'b1;
                        r_state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bus.M_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= bus.M_BRESP;
                        r_state     <= DONE;
                    end
                end
                RADDR: begin
                    if (bus.M_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (bus.M_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= bus.M_RDATA;
                        r_rsp_resp  <= bus.M_RRESP;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_resp  = r_rsp_resp;
    assign bus.M_AWADDR  = r_awaddr;
    assign bus.M_AWVALID = r_awvalid;
    assign bus.M_WDATA   = r_wdata;
    assign bus.M_WSTRB   = r_wstrb;
    assign bus.M_WVALID  = r_wvalid;
    assign bus.M_BREADY  = r_bready;
    assign bus.M_ARADDR  = r_araddr;
    assign bus.M_ARVALID = r_arvalid;
    assign bus.M_RREADY  = r_rready;
endmodule
